// File: rtl/layer_compositor_if.sv
// ----------------------------------------------------------------------------
// layer_compositor_if
//   CPU register bus for the layer compositor: a 2-bit register select, an
//   8-bit write port with a one-cycle write strobe, and a combinational
//   read-back of the selected register.
//
//   Signals
//     addr              register select (0 LAYER, 1 LEVEL, 2 FADE, 3 SPEED)
//     data_in           write data
//     write             write strobe, one cycle per write
//     control_data_out  read data for the register selected by addr
//
//   Modports
//     master  CPU side: drives addr/data_in/write, reads control_data_out
//     slave   compositor side: the inverse
// ----------------------------------------------------------------------------
interface layer_compositor_if;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic       write;
    logic [7:0] control_data_out;

    modport master (
        output addr,
        output data_in,
        output write,
        input  control_data_out
    );

    modport slave (
        input  addr,
        input  data_in,
        input  write,
        output control_data_out
    );
endinterface

// File: rtl/layer_compositor.sv
// ----------------------------------------------------------------------------
// layer_compositor
//   Merges the char, sprite and tilemap layers over a fixed background colour,
//   scales the result by a master brightness level and drives final video RGB.
//   The brightness level can be set directly by the CPU or stepped once per
//   frame by a fade engine (fade out to 0, fade in to FADE_MAX).
//
//   Ports
//     clk, reset              system clock, synchronous active-high reset
//     pause                   freezes the fade frame counter only
//     hblank, vblank          blanking flags aligned with the layer pixels
//     bus                     CPU register bus (layer_compositor_if.slave)
//     char_*, spr_*, tm_*     layer RGB plus 1-bit opacity
//     fade_busy               high while the fade engine is running
//     out_r/g/b               composited, brightness-scaled RGB
//     out_hblank, out_vblank  blanking flags delayed to match RGB
//
//   The pixel path is a fixed two-stage pipeline:
//     S1  layer priority select, registered with blanking and current level
//     S2  brightness scaling and blank forcing, registered to the outputs
// ----------------------------------------------------------------------------
module layer_compositor #(
    parameter logic [7:0] BG_R     = 8'h00,
    parameter logic [7:0] BG_G     = 8'h00,
    parameter logic [7:0] BG_B     = 8'h00,
    parameter logic [4:0] FADE_MAX = 5'd16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pause,
    input  logic                hblank,
    input  logic                vblank,
    layer_compositor_if.slave   bus,
    input  logic [7:0]          char_r,
    input  logic [7:0]          char_g,
    input  logic [7:0]          char_b,
    input  logic                char_a,
    input  logic [7:0]          spr_r,
    input  logic [7:0]          spr_g,
    input  logic [7:0]          spr_b,
    input  logic                spr_a,
    input  logic [7:0]          tm_r,
    input  logic [7:0]          tm_g,
    input  logic [7:0]          tm_b,
    input  logic                tm_a,
    output logic                fade_busy,
    output logic [7:0]          out_r,
    output logic [7:0]          out_g,
    output logic [7:0]          out_b,
    output logic                out_hblank,
    output logic                out_vblank
);

    // Fade engine states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OUT  = 2'd1;
    localparam logic [1:0] ST_IN   = 2'd2;

    localparam logic [7:0] LAYER_RESET = 8'h0E;
    localparam logic [7:0] SPEED_RESET = 8'd1;

    // ------------------------------------------------------------------------
    // CPU-visible registers and fade engine state
    // ------------------------------------------------------------------------
    logic [7:0] layer_reg;    // b0 sprite-over-char, b1 tm en, b2 char en, b3 spr en
    logic [4:0] level;
    logic [7:0] fade_reg;
    logic [7:0] speed_reg;
    logic [1:0] state;
    logic [7:0] frame_cnt;
    logic       vblank_prev;

    logic       wr_layer, wr_level, wr_fade, wr_speed;
    logic [4:0] level_clamped;
    logic [7:0] speed_eff;
    logic [8:0] cnt_next;
    logic       tick;
    logic       step;

    assign wr_layer = bus.write && (bus.addr == 2'd0);
    assign wr_level = bus.write && (bus.addr == 2'd1);
    assign wr_fade  = bus.write && (bus.addr == 2'd2);
    assign wr_speed = bus.write && (bus.addr == 2'd3);

    assign level_clamped = (bus.data_in[4:0] > FADE_MAX) ? FADE_MAX : bus.data_in[4:0];

    // SPEED of 0 behaves as 1 so a fade can never stall.
    assign speed_eff = (speed_reg == 8'd0) ? 8'd1 : speed_reg;

    // 9-bit increment so a counter left above a freshly lowered SPEED cannot
    // wrap; the >= compare then steps on the very next tick.
    assign cnt_next = {1'b0, frame_cnt} + 9'd1;
    assign step     = (cnt_next >= {1'b0, speed_eff});

    // One tick per vblank rising edge; pause freezes counting but the edge
    // detector keeps tracking vblank so no phantom edge appears on release.
    assign tick = vblank && !vblank_prev && !pause;

    assign fade_busy = (state != ST_IDLE);

    always_comb begin
        case (bus.addr)
            2'd0:    bus.control_data_out = layer_reg;
            2'd1:    bus.control_data_out = {3'b000, level};
            2'd2:    bus.control_data_out = fade_reg;
            default: bus.control_data_out = speed_reg;
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            layer_reg   <= LAYER_RESET;
            level       <= FADE_MAX;
            fade_reg    <= 8'd0;
            speed_reg   <= SPEED_RESET;
            state       <= ST_IDLE;
            frame_cnt   <= 8'd0;
            vblank_prev <= 1'b0;
        end else begin
            vblank_prev <= vblank;

            if (wr_layer) layer_reg <= bus.data_in;
            if (wr_speed) speed_reg <= bus.data_in;

            case (state)
                ST_IDLE: begin
                    // LEVEL and FADE are only writable while the engine is idle.
                    // A vblank edge coinciding with the start write is not counted.
                    if (wr_level) level <= level_clamped;
                    if (wr_fade) begin
                        fade_reg  <= bus.data_in;
                        frame_cnt <= 8'd0;
                        if (bus.data_in == 8'd1)      state <= ST_OUT;
                        else if (bus.data_in == 8'd2) state <= ST_IN;
                    end
                end

                ST_OUT: begin
                    if (tick) begin
                        if (step) begin
                            frame_cnt <= 8'd0;
                            if (level != 5'd0) level <= level - 5'd1;
                            // Finish on the step that reaches 0, or immediately
                            // if the fade was started already at 0.
                            if (level <= 5'd1) begin
                                fade_reg <= 8'd0;
                                state    <= ST_IDLE;
                            end
                        end else begin
                            frame_cnt <= cnt_next[7:0];
                        end
                    end
                end

                ST_IN: begin
                    if (tick) begin
                        if (step) begin
                            frame_cnt <= 8'd0;
                            if (level < FADE_MAX) level <= level + 5'd1;
                            if (level >= FADE_MAX - 5'd1) begin
                                fade_reg <= 8'd0;
                                state    <= ST_IDLE;
                            end
                        end else begin
                            frame_cnt <= cnt_next[7:0];
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // S1: layer priority select
    // ------------------------------------------------------------------------
    logic       char_op, spr_op, tm_op;
    logic [7:0] sel_r, sel_g, sel_b;

    assign char_op = layer_reg[2] & char_a;
    assign spr_op  = layer_reg[3] & spr_a;
    assign tm_op   = layer_reg[1] & tm_a;

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        sel_r = BG_R;
        sel_g = BG_G;
        sel_b = BG_B;
        if (layer_reg[0] && spr_op) begin
            sel_r = spr_r; sel_g = spr_g; sel_b = spr_b;
        end else if (char_op) begin
            sel_r = char_r; sel_g = char_g; sel_b = char_b;
        end else if (spr_op) begin
            sel_r = spr_r; sel_g = spr_g; sel_b = spr_b;
        end else if (tm_op) begin
            sel_r = tm_r; sel_g = tm_g; sel_b = tm_b;
        end
    end

    logic [7:0] s1_r, s1_g, s1_b;
    logic       s1_hblank, s1_vblank;
    logic [4:0] s1_level;

    // The level travels with the pixel so a level write between S1 and S2
    // cannot scale part of a pixel with the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r      <= 8'd0;
            s1_g      <= 8'd0;
            s1_b      <= 8'd0;
            s1_hblank <= 1'b0;
            s1_vblank <= 1'b0;
            s1_level  <= FADE_MAX;
        end else begin
            s1_r      <= sel_r;
            s1_g      <= sel_g;
            s1_b      <= sel_b;
            s1_hblank <= hblank;
            s1_vblank <= vblank;
            s1_level  <= level;
        end
    end

    // ------------------------------------------------------------------------
    // S2: brightness scaling, blank forcing
    // ------------------------------------------------------------------------
    // (c * level) >> 4: with FADE_MAX = 16 full level returns c unchanged.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [4:0] lv);
        logic [12:0] prod;
        prod = 13'(c) * 13'(lv);
        return prod[11:4];
    endfunction

    logic s1_blank;
    assign s1_blank = s1_hblank | s1_vblank;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_r      <= 8'd0;
            out_g      <= 8'd0;
            out_b      <= 8'd0;
            out_hblank <= 1'b0;
            out_vblank <= 1'b0;
        end else begin
            out_r      <= s1_blank ? 8'd0 : scale(s1_r, s1_level);
            out_g      <= s1_blank ? 8'd0 : scale(s1_g, s1_level);
            out_b      <= s1_blank ? 8'd0 : scale(s1_b, s1_level);
            out_hblank <= s1_hblank;
            out_vblank <= s1_vblank;
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// ----------------------------------------------------------------------------
// tb_layer_compositor
//   Self-checking bench for layer_compositor. Expected pixels are pushed into a
//   scoreboard queue when stimulus is driven and popped when the pipeline
//   delivers them two cycles later. Register and fade behaviour is checked
//   through the CPU read port.
// ----------------------------------------------------------------------------
module tb_layer_compositor;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hb;
        logic       vb;
    } pix_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       pause;
    logic       hblank, vblank;
    logic [7:0] char_r, char_g, char_b, spr_r, spr_g, spr_b, tm_r, tm_g, tm_b;
    logic       char_a, spr_a, tm_a;
    logic       fade_busy;
    logic [7:0] out_r, out_g, out_b;
    logic       out_hblank, out_vblank;

    layer_compositor_if bus ();

    layer_compositor #(
        .BG_R(8'd1), .BG_G(8'd2), .BG_B(8'd3), .FADE_MAX(5'd16)
    ) dut (
        .clk(clk), .reset(reset), .pause(pause),
        .hblank(hblank), .vblank(vblank),
        .bus(bus),
        .char_r(char_r), .char_g(char_g), .char_b(char_b), .char_a(char_a),
        .spr_r(spr_r), .spr_g(spr_g), .spr_b(spr_b), .spr_a(spr_a),
        .tm_r(tm_r), .tm_g(tm_g), .tm_b(tm_b), .tm_a(tm_a),
        .fade_busy(fade_busy),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_hblank(out_hblank), .out_vblank(out_vblank)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    pix_t exp_q[$];

    // ---------------- helpers (stimulus only) ----------------
    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        bus.addr    = a;
        bus.data_in = d;
        bus.write   = 1'b1;
        @(posedge clk); #1;
        bus.write   = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
        bus.addr = a;
        #1;
        d = bus.control_data_out;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vblank = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            vblank = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic set_layers(input logic [7:0] cr, cg, cb, input logic ca,
                              input logic [7:0] sr, sg, sb, input logic sa,
                              input logic [7:0] tr, tg, tb, input logic ta);
        char_r = cr; char_g = cg; char_b = cb; char_a = ca;
        spr_r  = sr; spr_g  = sg; spr_b  = sb; spr_a  = sa;
        tm_r   = tr; tm_g   = tg; tm_b   = tb; tm_a   = ta;
    endtask

    // Push the expected result for the inputs currently driven, let them
    // cross the two pipeline stages, then pop and compare.
    task automatic send_pixel(input string name, input pix_t e);
        pix_t got, want;
        exp_q.push_back(e);
        repeat (2) @(posedge clk);
        #1;
        want = exp_q.pop_front();
        got  = '{out_r, out_g, out_b, out_hblank, out_vblank};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got rgb=(%0d,%0d,%0d) hb=%b vb=%b, want rgb=(%0d,%0d,%0d) hb=%b vb=%b",
                     name, got.r, got.g, got.b, got.hb, got.vb,
                     want.r, want.g, want.b, want.hb, want.vb);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] d;
        logic [7:0] want [4];
        want[0] = 8'h0E; want[1] = 8'h10; want[2] = 8'h00; want[3] = 8'h01;
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), d);
            total++;
            if (d !== want[a]) begin
                bad++;
                $display("FAIL reset_reg%0d: got %h want %h", a, d, want[a]);
            end
        end
        total++;
        if ({out_r, out_g, out_b, out_hblank, out_vblank, fade_busy} !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs: got rgb=(%0d,%0d,%0d) hb=%b vb=%b busy=%b want all 0",
                     out_r, out_g, out_b, out_hblank, out_vblank, fade_busy);
        end
    endtask

    task automatic test_priority();
        cpu_write(2'd0, 8'h0E);
        set_layers(10, 20, 30, 1, 40, 50, 60, 1, 80, 80, 80, 1);
        send_pixel("char_over_sprite", '{8'd10, 8'd20, 8'd30, 1'b0, 1'b0});
        cpu_write(2'd0, 8'h0F);
        send_pixel("sprite_over_char", '{8'd40, 8'd50, 8'd60, 1'b0, 1'b0});
        // Char opaque but disabled, sprite disabled: tilemap shows through.
        cpu_write(2'd0, 8'h02);
        send_pixel("tilemap_only_enabled", '{8'd80, 8'd80, 8'd80, 1'b0, 1'b0});
        cpu_write(2'd0, 8'h0E);
    endtask

    task automatic test_background();
        set_layers(10, 20, 30, 0, 40, 50, 60, 0, 80, 80, 80, 0);
        send_pixel("background", '{8'd1, 8'd2, 8'd3, 1'b0, 1'b0});
        tm_a = 1'b1;
        send_pixel("tilemap_over_bg", '{8'd80, 8'd80, 8'd80, 1'b0, 1'b0});
        hblank = 1'b1;
        send_pixel("hblank_forces_black", '{8'd0, 8'd0, 8'd0, 1'b1, 1'b0});
        hblank = 1'b0;
    endtask

    task automatic test_brightness();
        logic [7:0] d;
        set_layers(200, 100, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cpu_write(2'd1, 8'd8);
        send_pixel("half_level", '{8'd100, 8'd50, 8'd3, 1'b0, 1'b0});
        cpu_write(2'd1, 8'd31);
        read_reg(2'd1, d);
        total++;
        if (d !== 8'd16) begin
            bad++;
            $display("FAIL level_clamp: got %0d want 16", d);
        end
        send_pixel("full_level", '{8'd200, 8'd100, 8'd7, 1'b0, 1'b0});
        cpu_write(2'd1, 8'd0);
        send_pixel("zero_level", '{8'd0, 8'd0, 8'd0, 1'b0, 1'b0});
        cpu_write(2'd1, 8'd16);
    endtask

    task automatic expect_fade(input string name, input logic [7:0] lvl,
                               input logic [7:0] r2, input logic busy);
        logic [7:0] dl, df;
        read_reg(2'd1, dl);
        read_reg(2'd2, df);
        total++;
        if (dl !== lvl || df !== r2 || fade_busy !== busy) begin
            bad++;
            $display("FAIL %s: got level=%0d reg2=%0d busy=%b want level=%0d reg2=%0d busy=%b",
                     name, dl, df, fade_busy, lvl, r2, busy);
        end
    endtask

    task automatic test_fade();
        cpu_write(2'd3, 8'd2);
        cpu_write(2'd2, 8'd1);
        expect_fade("fade_out_start", 16, 1, 1);
        frames(1);
        expect_fade("fade_out_1frame", 16, 1, 1);
        frames(1);
        expect_fade("fade_out_2frames", 15, 1, 1);
        frames(28);
        expect_fade("fade_out_30frames", 1, 1, 1);
        frames(2);
        expect_fade("fade_out_done", 0, 0, 0);
        cpu_write(2'd2, 8'd2);
        frames(31);
        expect_fade("fade_in_31frames", 15, 2, 1);
        frames(1);
        expect_fade("fade_in_done", 16, 0, 0);
        // Fade in already at full level ends on the first step attempt.
        cpu_write(2'd3, 8'd0);
        cpu_write(2'd2, 8'd2);
        frames(1);
        expect_fade("fade_in_at_target", 16, 0, 0);
        // Unknown trigger value is stored without starting the engine.
        cpu_write(2'd2, 8'd5);
        expect_fade("fade_other_value", 16, 5, 0);
    endtask

    task automatic test_pause_reset();
        logic [7:0] d;
        cpu_write(2'd3, 8'd1);
        cpu_write(2'd2, 8'd1);
        frames(3);
        expect_fade("pause_prefade", 13, 1, 1);
        pause = 1'b1;
        frames(5);
        expect_fade("pause_frozen", 13, 1, 1);
        cpu_write(2'd1, 8'd4);
        expect_fade("level_write_busy", 13, 1, 1);
        pause = 1'b0;
        frames(1);
        expect_fade("pause_released", 12, 1, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        expect_fade("reset_mid_fade", 16, 0, 0);
        read_reg(2'd0, d);
        total++;
        if (d !== 8'h0E) begin
            bad++;
            $display("FAIL reset_mid_fade_reg0: got %h want 0e", d);
        end
        read_reg(2'd3, d);
        total++;
        if (d !== 8'h01) begin
            bad++;
            $display("FAIL reset_mid_fade_reg3: got %h want 01", d);
        end
    endtask

    // One new pixel every cycle at half level; pixel 4 is inside hblank.
    task automatic test_back_to_back();
        pix_t got, want;
        cpu_write(2'd1, 8'd8);
        for (int i = 0; i < 11; i++) begin
            if (i < 10) begin
                char_r = 8'(i * 25);
                char_g = 8'(255 - i * 20);
                char_b = 8'(i * 7 + 3);
                char_a = 1'b1;
                hblank = (i == 4);
                if (i == 4) exp_q.push_back('{8'd0, 8'd0, 8'd0, 1'b1, 1'b0});
                else        exp_q.push_back('{char_r >> 1, char_g >> 1, char_b >> 1, 1'b0, 1'b0});
            end
            @(posedge clk); #1;
            if (i >= 1) begin
                want = exp_q.pop_front();
                got  = '{out_r, out_g, out_b, out_hblank, out_vblank};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL b2b_pixel%0d: got rgb=(%0d,%0d,%0d) hb=%b want rgb=(%0d,%0d,%0d) hb=%b",
                             i - 1, got.r, got.g, got.b, got.hb, want.r, want.g, want.b, want.hb);
                end
            end
        end
        hblank = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pause = 1'b0;
        hblank = 1'b0;
        vblank = 1'b0;
        bus.addr = 2'd0;
        bus.data_in = 8'd0;
        bus.write = 1'b0;
        set_layers(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        test_reset();
        test_priority();
        test_background();
        test_brightness();
        test_fade();
        test_pause_reset();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
